// File: rtl/dm_dmi_arb.sv
// Round-robin arbiter sharing one DMI target port among NumReq requesters.
// Responses are steered back in request order through an in-order ID FIFO.
module dm_dmi_arb #(
  parameter int NumReq    = 2,
  parameter int FifoDepth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumReq-1:0]    slv_req_valid_i,
  output logic [NumReq-1:0]    slv_req_ready_o,
  input  logic [NumReq*41-1:0] slv_req_i,
  output logic [NumReq-1:0]    slv_resp_valid_o,
  input  logic [NumReq-1:0]    slv_resp_ready_i,
  output logic [33:0]          slv_resp_o,
  output logic                 mst_req_valid_o,
  input  logic                 mst_req_ready_i,
  output logic [40:0]          mst_req_o,
  input  logic                 mst_resp_valid_i,
  output logic                 mst_resp_ready_o,
  input  logic [33:0]          mst_resp_i,
  output logic                 busy_o,
  output logic                 spurious_resp_o
);

  localparam int ReqW = 41;
  localparam int IdxW = $clog2(NumReq);
  localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW = $clog2(FifoDepth + 1);

  typedef enum logic {ARB, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   rr_q, lock_idx_q;
  logic [IdxW-1:0]   rr_grant, grant;
  logic              rr_found, any_valid;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [IdxW-1:0]   id_mem [FifoDepth];
  logic [IdxW-1:0]   head;
  logic              fifo_full, fifo_empty;
  logic              push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full  = (count_q == CntW'(FifoDepth));
  assign fifo_empty = (count_q == '0);
  assign head       = id_mem[rd_ptr_q];
  assign busy_o     = !fifo_empty;
  assign slv_resp_o = mst_resp_i;

  // Rotating priority search starting at rr_q.
  always_comb begin : p_rr
    int idx;
    idx      = 0;
    rr_grant = rr_q;
    rr_found = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NumReq) idx = idx - NumReq;
      if (!rr_found && slv_req_valid_i[idx]) begin
        rr_found = 1'b1;
        rr_grant = IdxW'(idx);
      end
    end
  end

  // LOCKED freezes the grant so the DM sees a stable request while stalling.
  always_comb begin
    state_d         = state_q;
    grant           = rr_grant;
    any_valid       = rr_found;
    slv_req_ready_o = '0;
    if (state_q == LOCKED) begin
      grant     = lock_idx_q;
      any_valid = slv_req_valid_i[lock_idx_q];
    end
    mst_req_valid_o        = any_valid && !fifo_full;
    mst_req_o              = slv_req_i[int'(grant)*ReqW +: ReqW];
    slv_req_ready_o[grant] = mst_req_ready_i && !fifo_full;
    push                   = mst_req_valid_o && mst_req_ready_i;
    case (state_q)
      ARB:     if (mst_req_valid_o && !mst_req_ready_i) state_d = LOCKED;
      LOCKED:  if (push) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    slv_resp_valid_o = '0;
    mst_resp_ready_o = 1'b1;
    spurious_resp_o  = 1'b0;
    if (!fifo_empty) begin
      slv_resp_valid_o[head] = mst_resp_valid_i;
      mst_resp_ready_o       = slv_resp_ready_i[head];
    end else begin
      spurious_resp_o = mst_resp_valid_i;
    end
    pop = mst_resp_valid_i && mst_resp_ready_o && !fifo_empty;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ARB;
      rr_q       <= '0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ARB && state_d == LOCKED) lock_idx_q <= grant;
      if (push) begin
        rr_q     <= (grant == IdxW'(NumReq - 1)) ? '0 : grant + 1'b1;
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) id_mem[wr_ptr_q] <= grant;
  end

endmodule

// File: tb/tb_dm_dmi_arb.sv
// Directed bench for dm_dmi_arb (NumReq=2, FifoDepth=2) with hand-computed expectations.
module tb_dm_dmi_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [40:0] req0, req1, mreq;
  logic [81:0] slv_req;
  logic [33:0] sresp, mresp;
  logic        mreq_valid, mreq_ready, mresp_valid, mresp_ready, busy, spurious;

  int errors = 0;
  int checks = 0;

  assign slv_req = {req1, req0};

  always #5 clk = ~clk;

  dm_dmi_arb #(.NumReq(2), .FifoDepth(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .slv_req_valid_i(req_valid), .slv_req_ready_o(req_ready), .slv_req_i(slv_req),
    .slv_resp_valid_o(resp_valid), .slv_resp_ready_i(resp_ready), .slv_resp_o(sresp),
    .mst_req_valid_o(mreq_valid), .mst_req_ready_i(mreq_ready), .mst_req_o(mreq),
    .mst_resp_valid_i(mresp_valid), .mst_resp_ready_o(mresp_ready), .mst_resp_i(mresp),
    .busy_o(busy), .spurious_resp_o(spurious)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; req0 = '0; req1 = '0;
    resp_ready = 2'b00; mreq_ready = 1'b0; mresp_valid = 1'b0; mresp = '0;

    // Reset: outputs quiet, request path still follows inputs.
    @(negedge clk);
    req_valid = 2'b11; req0 = 41'h0_0000_0A00; req1 = 41'h0_0000_0A01;
    #1;
    check("rst_busy", busy, 0);
    check("rst_spur", spurious, 0);
    check("rst_rvld", resp_valid, 0);
    check("rst_mvld", mreq_valid, 1);
    check("rst_mreq", mreq, 41'h0_0000_0A00);

    // Round robin with a response each cycle.
    @(negedge clk);
    rst = 1'b0; mreq_ready = 1'b1; resp_ready = 2'b11;
    #1;
    check("rr0_req", mreq, 41'h0_0000_0A00);
    check("rr0_rdy", req_ready, 2'b01);

    @(negedge clk);
    req0 = 41'h0_0000_0B00; mresp_valid = 1'b1; mresp = 34'h1_0000_0000;
    #1;
    check("rr1_req", mreq, 41'h0_0000_0A01);
    check("rr1_rdy", req_ready, 2'b10);
    check("rr1_busy", busy, 1);
    check("rr1_rvld", resp_valid, 2'b01);
    check("rr1_rdat", sresp, 34'h1_0000_0000);
    check("rr1_mrdy", mresp_ready, 1);

    @(negedge clk);
    req1 = 41'h0_0000_0B01; mresp = 34'h1_0000_0001;
    #1;
    check("rr2_req", mreq, 41'h0_0000_0B00);
    check("rr2_rdy", req_ready, 2'b01);
    check("rr2_rvld", resp_valid, 2'b10);
    check("rr2_rdat", sresp, 34'h1_0000_0001);

    @(negedge clk);
    req_valid = 2'b10; mresp = 34'h1_0000_0002;
    #1;
    check("rr3_req", mreq, 41'h0_0000_0B01);
    check("rr3_rdy", req_ready, 2'b10);
    check("rr3_rvld", resp_valid, 2'b01);

    @(negedge clk);
    req_valid = 2'b00; mresp = 34'h1_0000_0003;
    #1;
    check("rr4_mvld", mreq_valid, 0);
    check("rr4_rvld", resp_valid, 2'b10);

    // Lock under stall: req1 first, req0 joins on the second cycle.
    @(negedge clk);
    mresp_valid = 1'b0; req_valid = 2'b10; req1 = 41'h0_0000_0C01; mreq_ready = 1'b0;
    #1;
    check("drain_busy", busy, 0);
    check("lk0_req", mreq, 41'h0_0000_0C01);
    check("lk0_mvld", mreq_valid, 1);

    @(negedge clk);
    req_valid = 2'b11; req0 = 41'h0_0000_0C00;
    #1;
    check("lk1_req", mreq, 41'h0_0000_0C01);
    step();
    check("lk2_req", mreq, 41'h0_0000_0C01);

    @(negedge clk);
    mreq_ready = 1'b1;
    #1;
    check("lk3_req", mreq, 41'h0_0000_0C01);
    check("lk3_rdy", req_ready, 2'b10);

    @(negedge clk);
    req_valid = 2'b01;
    #1;
    check("lk4_req", mreq, 41'h0_0000_0C00);
    check("lk4_rdy", req_ready, 2'b01);

    // FIFO full with IDs {1,0}: nothing accepted.
    @(negedge clk);
    req_valid = 2'b11; req1 = 41'h0_0000_0F01;
    #1;
    check("full_mvld", mreq_valid, 0);
    check("full_rdy", req_ready, 2'b00);

    // Backpressure: head is ID 1, port 1 not ready.
    @(negedge clk);
    mresp_valid = 1'b1; mresp = 34'h2_0000_0001; resp_ready = 2'b01;
    #1;
    check("bp_mrdy", mresp_ready, 0);
    check("bp_rvld", resp_valid, 2'b10);
    step();
    check("bp_hold", resp_valid, 2'b10);

    // Pop this cycle does not admit a request in the same cycle.
    @(negedge clk);
    resp_ready = 2'b11;
    #1;
    check("pop_mrdy", mresp_ready, 1);
    check("pop_mvld", mreq_valid, 0);
    check("pop_rdy", req_ready, 2'b00);

    @(negedge clk);
    mresp_valid = 1'b0;
    #1;
    check("aft_mvld", mreq_valid, 1);
    check("aft_req", mreq, 41'h0_0000_0F01);
    check("aft_rdy", req_ready, 2'b10);

    // Reset mid-cycle with two IDs outstanding.
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check("pre_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_busy", busy, 0);

    @(negedge clk);
    rst = 1'b0; mresp_valid = 1'b1; mresp = 34'h3_0000_0000;
    req_valid = 2'b11; req0 = 41'h0_0000_0D00; req1 = 41'h0_0000_0D01; mreq_ready = 1'b0;
    #1;
    check("sp_spur", spurious, 1);
    check("sp_mrdy", mresp_ready, 1);
    check("sp_rvld", resp_valid, 2'b00);
    check("post_req", mreq, 41'h0_0000_0D00);

    @(negedge clk);
    mresp_valid = 1'b0;
    #1;
    check("sp_clr", spurious, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
